// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller: memory-wait stalls, taken-jump redirect with
//   multi-cycle ID/EX bubble insertion, and load-use stalls. Hold/flush/jump
//   outputs are combinational from the current state and inputs; the state,
//   the flush countdown and the two statistics counters are registered.
//
//   State table
//     state    | meaning
//     RUN      | normal flow; memory wait > jump > load-use
//     FLUSH    | inserting bubbles after an accepted jump; r_flush_rem left
//     MEM_WAIT | MEM-stage access outstanding; holds until ack
//     (3)      | unreachable; returns to RUN
//
//   Ports
//     clk, rst                      clock, async active-low reset
//     hc_jump_flag_in/addr_in       resolved taken jump and its target
//     hc_ex_load_in/write_addr_in   EX load flag and destination register
//     hc_id_reg{1,2}_addr/used_in   ID source registers and their use flags
//     hc_mem_req_in/ack_in          MEM-stage access handshake
//     hc_*_hold_out/flush_out       pipeline register control
//     hc_pc_jump_en/addr_out        PC redirect
//     hc_state_out                  FSM state
//     hc_stall_cnt_out              saturating count of pc_hold cycles
//     hc_flush_cnt_out              saturating count of accepted jumps
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hc_jump_flag_in,
  input  logic [31:0] hc_jump_addr_in,
  input  logic        hc_ex_load_in,
  input  logic [4:0]  hc_ex_write_addr_in,
  input  logic [4:0]  hc_id_reg1_addr_in,
  input  logic [4:0]  hc_id_reg2_addr_in,
  input  logic        hc_id_reg1_used_in,
  input  logic        hc_id_reg2_used_in,
  input  logic        hc_mem_req_in,
  input  logic        hc_mem_ack_in,
  output logic        hc_pc_hold_out,
  output logic        hc_if_id_hold_out,
  output logic        hc_if_id_flush_out,
  output logic        hc_id_ex_hold_out,
  output logic        hc_id_ex_flush_out,
  output logic        hc_pc_jump_en_out,
  output logic [31:0] hc_pc_jump_addr_out,
  output logic [1:0]  hc_state_out,
  output logic [15:0] hc_stall_cnt_out,
  output logic [15:0] hc_flush_cnt_out
);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_FLUSH    = 2'd1;
  localparam logic [1:0] S_MEM_WAIT = 2'd2;

  // The accept cycle is the first bubble, so FLUSH covers the remainder.
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [3:0]  r_flush_rem;
  logic [3:0]  w_flush_rem_nxt;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;
  logic        w_mem_wait;
  logic        w_load_use;
  logic        w_jump_acc;

  assign w_mem_wait = hc_mem_req_in & ~hc_mem_ack_in;

  // Register 0 is hardwired zero, so it can never carry a dependency.
  assign w_load_use = hc_ex_load_in && (hc_ex_write_addr_in != 5'd0) &&
                      ((hc_id_reg1_used_in && (hc_id_reg1_addr_in == hc_ex_write_addr_in)) ||
                       (hc_id_reg2_used_in && (hc_id_reg2_addr_in == hc_ex_write_addr_in)));

  always_comb begin
    hc_pc_hold_out     = 1'b0;
    hc_if_id_hold_out  = 1'b0;
    hc_if_id_flush_out = 1'b0;
    hc_id_ex_hold_out  = 1'b0;
    hc_id_ex_flush_out = 1'b0;
    hc_pc_jump_en_out  = 1'b0;
    w_jump_acc         = 1'b0;
    w_state_nxt        = r_state;
    w_flush_rem_nxt    = r_flush_rem;

    case (r_state)
      S_RUN, S_MEM_WAIT: begin
        // Once in MEM_WAIT only the ack matters; req may already have dropped.
        if ((r_state == S_RUN) ? w_mem_wait : !hc_mem_ack_in) begin
          hc_pc_hold_out    = 1'b1;
          hc_if_id_hold_out = 1'b1;
          hc_id_ex_hold_out = 1'b1;
          w_state_nxt       = S_MEM_WAIT;
        end else begin
          w_state_nxt = S_RUN;
          if (hc_jump_flag_in) begin
            w_jump_acc = 1'b1;
          end else if (w_load_use) begin
            hc_pc_hold_out     = 1'b1;
            hc_if_id_hold_out  = 1'b1;
            hc_id_ex_flush_out = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        hc_if_id_flush_out = 1'b1;
        hc_id_ex_flush_out = 1'b1;
        if (w_mem_wait) begin
          // Count frozen while the pipe is held.
          hc_pc_hold_out    = 1'b1;
          hc_if_id_hold_out = 1'b1;
          hc_id_ex_hold_out = 1'b1;
        end else if (hc_jump_flag_in) begin
          w_jump_acc = 1'b1;
        end else if (r_flush_rem <= 4'd1) begin
          w_state_nxt     = S_RUN;
          w_flush_rem_nxt = 4'd0;
        end else begin
          w_flush_rem_nxt = r_flush_rem - 4'd1;
        end
      end
      default: begin
        w_state_nxt     = S_RUN;
        w_flush_rem_nxt = 4'd0;
      end
    endcase

    if (w_jump_acc) begin
      hc_pc_jump_en_out  = 1'b1;
      hc_if_id_flush_out = 1'b1;
      hc_id_ex_flush_out = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        w_state_nxt     = S_FLUSH;
        w_flush_rem_nxt = FLUSH_RELOAD;
      end else begin
        w_state_nxt     = S_RUN;
        w_flush_rem_nxt = 4'd0;
      end
    end
  end

  assign hc_pc_jump_addr_out = hc_pc_jump_en_out ? hc_jump_addr_in : 32'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_RUN;
      r_flush_rem <= 4'd0;
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_rem <= w_flush_rem_nxt;
      if (hc_pc_hold_out && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_jump_acc && (r_flush_cnt != 16'hFFFF)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign hc_state_out     = r_state;
  assign hc_stall_cnt_out = r_stall_cnt;
  assign hc_flush_cnt_out = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed bench for hazard_ctrl (FLUSH_CYCLES = 2). Each stimulus cycle
//   pushes its hand-computed expected output vector into a scoreboard queue;
//   a monitor on the falling edge pops and compares against the DUT.
//   Control vector bit order: {pc_hold, if_id_hold, if_id_flush,
//   id_ex_hold, id_ex_flush, jump_en}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  typedef struct packed {
    logic [5:0]  ctl;
    logic [31:0] addr;
    logic [1:0]  st;
    logic [15:0] sc;
    logic [15:0] fc;
  } vec_t;

  typedef struct {
    int   id;
    vec_t v;
  } sb_t;

  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_JUMP  = 6'b001011;
  localparam logic [5:0] C_FLUSH = 6'b001010;
  localparam logic [5:0] C_LU    = 6'b110010;
  localparam logic [5:0] C_MW    = 6'b110100;
  localparam logic [5:0] C_MWF   = 6'b111110;

  logic        clk;
  logic        rst;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        ex_load;
  logic [4:0]  ex_write;
  logic [4:0]  reg1, reg2;
  logic        used1, used2;
  logic        mem_req, mem_ack;
  logic        pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, jump_en;
  logic [31:0] jump_addr_out;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  hazard_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .hc_jump_flag_in     (jump_flag),
    .hc_jump_addr_in     (jump_addr),
    .hc_ex_load_in       (ex_load),
    .hc_ex_write_addr_in (ex_write),
    .hc_id_reg1_addr_in  (reg1),
    .hc_id_reg2_addr_in  (reg2),
    .hc_id_reg1_used_in  (used1),
    .hc_id_reg2_used_in  (used2),
    .hc_mem_req_in       (mem_req),
    .hc_mem_ack_in       (mem_ack),
    .hc_pc_hold_out      (pc_hold),
    .hc_if_id_hold_out   (if_id_hold),
    .hc_if_id_flush_out  (if_id_flush),
    .hc_id_ex_hold_out   (id_ex_hold),
    .hc_id_ex_flush_out  (id_ex_flush),
    .hc_pc_jump_en_out   (jump_en),
    .hc_pc_jump_addr_out (jump_addr_out),
    .hc_state_out        (state),
    .hc_stall_cnt_out    (stall_cnt),
    .hc_flush_cnt_out    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: compares at the falling edge, mid-cycle after inputs settle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t  e;
      vec_t a;
      e = sb.pop_front();
      a = '{ctl: {pc_hold, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, jump_en},
            addr: jump_addr_out, st: state, sc: stall_cnt, fc: flush_cnt};
      checks++;
      if (a !== e.v) begin
        errors++;
        $display("FAIL step%0d: got ctl=%b addr=%h st=%0d stall=%h flush=%h, want ctl=%b addr=%h st=%0d stall=%h flush=%h",
                 e.id, a.ctl, a.addr, a.st, a.sc, a.fc, e.v.ctl, e.v.addr, e.v.st, e.v.sc, e.v.fc);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic jf, input logic [31:0] ja, input logic ld,
                        input logic [4:0] wr, input logic [4:0] r1, input logic [4:0] r2,
                        input logic u1, input logic u2, input logic mq, input logic ma);
    jump_flag = jf; jump_addr = ja; ex_load = ld; ex_write = wr;
    reg1 = r1; reg2 = r2; used1 = u1; used2 = u2; mem_req = mq; mem_ack = ma;
  endtask

  task automatic idle();
    set_in(0, 32'd0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
  endtask

  task automatic exp(input int id, input logic [5:0] ctl, input logic [31:0] addr,
                     input logic [1:0] st, input logic [15:0] sc, input logic [15:0] fc);
    sb_t e;
    e.id = id;
    e.v  = '{ctl: ctl, addr: addr, st: st, sc: sc, fc: fc};
    sb.push_back(e);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    repeat (2) cyc();
    rst = 1'b1;
    exp(1, C_NONE, 0, 0, 0, 0);

    // Jump with FLUSH_CYCLES=2: accept cycle, one FLUSH cycle, back to RUN.
    cyc(); set_in(1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0); exp(2, C_JUMP, 32'h100, 0, 0, 0);
    cyc(); set_in(0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0); exp(3, C_FLUSH, 0, 1, 0, 1);
    cyc(); idle();                                     exp(4, C_NONE, 0, 0, 0, 1);

    // Load-use and non-hazard variants.
    cyc(); set_in(0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 0); exp(5, C_LU, 0, 0, 0, 1);
    cyc(); set_in(0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0); exp(6, C_NONE, 0, 0, 1, 1);
    cyc(); set_in(0, 0, 1, 5'd7, 5'd7, 5'd0, 0, 0, 0, 0); exp(7, C_NONE, 0, 0, 1, 1);
    cyc(); set_in(0, 0, 0, 5'd7, 5'd7, 5'd0, 1, 0, 0, 0); exp(8, C_NONE, 0, 0, 1, 1);

    // Memory wait for three cycles, released by ack.
    cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); exp(9,  C_MW, 0, 0, 1, 1);
    cyc();                                       exp(10, C_MW, 0, 2, 2, 1);
    cyc();                                       exp(11, C_MW, 0, 2, 3, 1);
    cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); exp(12, C_NONE, 0, 2, 4, 1);
    cyc(); idle();                               exp(13, C_NONE, 0, 0, 4, 1);

    // Jump pending behind a memory wait, accepted on ack.
    cyc(); set_in(1, 32'h200, 0, 0, 0, 0, 0, 0, 1, 0); exp(14, C_MW, 0, 0, 4, 1);
    cyc();                                             exp(15, C_MW, 0, 2, 5, 1);
    cyc(); set_in(1, 32'h200, 0, 0, 0, 0, 0, 0, 1, 1); exp(16, C_JUMP, 32'h200, 2, 6, 1);
    // Memory wait inside FLUSH: holds plus flushes, count frozen.
    cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);       exp(17, C_MWF, 0, 1, 6, 2);
    cyc(); idle();                                     exp(18, C_FLUSH, 0, 1, 7, 2);
    cyc();                                             exp(19, C_NONE, 0, 0, 7, 2);

    // Jump re-accepted while in FLUSH reloads the count.
    cyc(); set_in(1, 32'h300, 0, 0, 0, 0, 0, 0, 0, 0); exp(20, C_JUMP, 32'h300, 0, 7, 2);
    cyc(); set_in(1, 32'h400, 0, 0, 0, 0, 0, 0, 0, 0); exp(21, C_JUMP, 32'h400, 1, 7, 3);
    cyc(); idle();                                     exp(22, C_FLUSH, 0, 1, 7, 4);

    // Jump outranks a simultaneous load-use; then reset mid-FLUSH.
    cyc(); set_in(1, 32'h500, 1, 5'd3, 5'd3, 0, 1, 0, 0, 0); exp(23, C_JUMP, 32'h500, 0, 7, 4);
    cyc(); rst = 1'b0; idle();                               exp(24, C_NONE, 0, 0, 0, 0);
    cyc(); rst = 1'b1;                                       exp(25, C_NONE, 0, 0, 0, 0);

    // Reset mid-MEM_WAIT.
    cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); exp(26, C_MW, 0, 0, 0, 0);
    cyc();                                       exp(27, C_MW, 0, 2, 1, 0);
    cyc(); rst = 1'b0; idle();                   exp(28, C_NONE, 0, 0, 0, 0);
    cyc(); rst = 1'b1;                           exp(29, C_NONE, 0, 0, 0, 0);

    // Stall counter saturation.
    cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (65540) cyc();
    exp(30, C_MW, 0, 2, 16'hFFFF, 0);
    cyc(); set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); exp(31, C_NONE, 0, 2, 16'hFFFF, 0);
    cyc(); idle();                               exp(32, C_NONE, 0, 0, 16'hFFFF, 0);

    begin
      int n;
      n = 0;
      while (sb.size() > 0 && n < 10) begin
        @(posedge clk);
        n++;
      end
      if (sb.size() > 0) begin
        errors++;
        $display("FAIL drain: %0d scoreboard entries left, want 0", sb.size());
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2: total cycles of ID/EX bubble insertion per taken jump, legal range 1..15.
REQ-002 SHALL have ports (name, direction, width, meaning), in this order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- hc_jump_flag_in  in  1  EX resolved taken jump/branch.
- hc_jump_addr_in  in  32  jump target.
- hc_ex_load_in  in  1  EX instruction is a load.
- hc_ex_write_addr_in  in  5  EX destination register.
- hc_id_reg1_addr_in, hc_id_reg2_addr_in  in  5 each  ID source registers.
- hc_id_reg1_used_in, hc_id_reg2_used_in  in  1 each  ID source actually read.
- hc_mem_req_in  in  1  MEM-stage access in progress.
- hc_mem_ack_in  in  1  memory access completes this cycle.
- hc_pc_hold_out  out  1  freeze PC.
- hc_if_id_hold_out  out  1  freeze IF/ID register.
- hc_if_id_flush_out  out  1  zero IF/ID register.
- hc_id_ex_hold_out  out  1  freeze ID/EX decode-delay register.
- hc_id_ex_flush_out  out  1  load ID/EX with reset values (bubble).
- hc_pc_jump_en_out  out  1  redirect PC.
- hc_pc_jump_addr_out  out  32  redirect target.
- hc_state_out  out  2  FSM state.
- hc_stall_cnt_out  out  16  saturating stall-cycle count.
- hc_flush_cnt_out  out  16  saturating accepted-jump count.

Function
REQ-003 SHALL implement FSM states RUN=0, FLUSH=1, MEM_WAIT=2; encoding 3 is unreachable and SHALL return to RUN on the next edge.
REQ-004 All hold/flush/jump outputs SHALL be combinational from the current state and inputs, with zero-cycle latency; the state and counters SHALL be registered.
REQ-005 Condition priority in RUN SHALL be memory wait, then jump, then load-use; only the highest active condition acts.
REQ-006 Memory wait is hc_mem_req_in=1 and hc_mem_ack_in=0. In RUN it SHALL:
- assert pc_hold, if_id_hold and id_ex_hold that cycle, with flushes and jump_en at 0;
- move the next state to MEM_WAIT.
REQ-007 In MEM_WAIT with hc_mem_ack_in=0, all three holds SHALL stay asserted and the state SHALL remain MEM_WAIT.
REQ-008 In MEM_WAIT with hc_mem_ack_in=1, the holds SHALL deassert that cycle and the jump and load-use rules SHALL be evaluated exactly as in RUN.
REQ-009 A jump is accepted when hc_jump_flag_in=1 and no memory wait is active. In the accept cycle the block SHALL:
- assert jump_en, if_id_flush and id_ex_flush;
- drive jump_addr = hc_jump_addr_in;
- enter FLUSH with remaining-count FLUSH_CYCLES-1, or return to RUN when FLUSH_CYCLES=1.
REQ-010 In FLUSH, id_ex_flush and if_id_flush SHALL assert every cycle; the count SHALL decrement each cycle and the state SHALL return to RUN in the cycle after the count reaches 1.
REQ-011 A memory wait arising in FLUSH SHALL assert the holds and suspend the count; both flushes stay asserted.
REQ-012 A jump accepted while in FLUSH SHALL reload the count and redirect again.
REQ-013 Load-use hazard: hc_ex_load_in=1, hc_ex_write_addr_in≠0, and a used ID source matches it. When it is the highest active condition the block SHALL assert pc_hold, if_id_hold and id_ex_flush for that cycle only, and the state SHALL remain RUN.
REQ-014 A register address of 0 SHALL never create a hazard.
REQ-015 hc_pc_jump_addr_out SHALL be 0 whenever jump_en=0.
REQ-016 hc_stall_cnt_out SHALL increment on every cycle with pc_hold=1, saturating at 16'hFFFF.
REQ-017 hc_flush_cnt_out SHALL increment on every accepted jump, saturating at 16'hFFFF.

Reset
REQ-018 rst=0 SHALL immediately force state RUN, clear the FLUSH count and zero both counters, regardless of the clock.
REQ-019 With no inputs active after reset, all outputs SHALL be 0.
REQ-020 Reset asserted mid-FLUSH or mid-MEM_WAIT SHALL abandon the operation, and no hold or flush SHALL persist after release.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Jump: jump_flag=1, addr=32'h0000_0100 in RUN, FLUSH_CYCLES=2 -> same cycle jump_en=1, addr=0x100, both flushes=1; next cycle FLUSH with flushes=1; then RUN; flush_cnt=1.
- Load-use: ex_load=1, ex_write=5, id_reg2=5 used -> one cycle of pc_hold=1, if_id_hold=1, id_ex_flush=1; stall_cnt=1; ex_write=0 gives no stall.
- Memory wait: mem_req=1, ack=0 for 3 cycles, then ack=1 -> holds=1 for 3 cycles, 0 in the ack cycle; stall_cnt=3.
- Memory wait with pending jump: mem wait and jump_flag=1 together -> holds only; on ack, jump accepted that cycle.
- Reset: rst low mid-FLUSH and mid-MEM_WAIT -> state_out=0, all outputs 0 at once, counters 0.
- Saturation: preload by 65535+ stalls -> stall_cnt holds at 16'hFFFF.
